dct_buffer_drain_fsm: RTL and testbench

Consumer end of the DCT output buffer ring.
- Tracks the DCT manager's 2-bit output-buffer pointer (dcts_frontbuffer).
- Counts buffers the DCTs have completed but that have not yet been read.
- Reads each completed 64-word buffer from the coefficient RAM in order and streams the words downstream (quantizer/entropy coder) over a valid/ready handshake.
- Releases each buffer after its last word is accepted, and flags overrun when the writer laps the reader.

---
 rtl/jfpjc_dct_pkg.sv | 15 +
 rtl/zigzag_lut.sv | 20 ++
 rtl/dct_buffer_drain_fsm.sv | 134 +++++++++++++
 tb/tb_dct_buffer_drain_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_dct_pkg.sv
// rtl/jfpjc_dct_pkg.sv - shared encodings and sizes for the DCT output buffer drain
package jfpjc_dct_pkg;

    localparam int BLOCK_WORDS     = 64;
    localparam int NUM_DCT_BUFFERS = 4;
    localparam int BUF_PTR_W       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } drain_state_t;

endpackage

// File: rtl/zigzag_lut.sv
// rtl/zigzag_lut.sv - combinational JPEG zigzag beat-to-raster-offset ROM
module zigzag_lut (
    input  logic [5:0] k,
    output logic [5:0] offset
);

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    assign offset = ZZ[k];

endmodule

// File: rtl/dct_buffer_drain_fsm.sv
// rtl/dct_buffer_drain_fsm.sv - drains completed DCT buffers to a valid/ready stream (ZIGZAG_ORDER_EN: zigzag read order)
module dct_buffer_drain_fsm
    import jfpjc_dct_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int GROUPS_PER_FRAME = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BUF_PTR_W-1:0]  dcts_frontbuffer,
    output logic                  rd_en,
    output logic [BUF_PTR_W-1:0]  rd_buffer,
    output logic [5:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [2:0]            blocks_read,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam logic [5:0] LAST_BEAT  = 6'(BLOCK_WORDS - 1);
    localparam logic [2:0] LAST_BLOCK = 3'(GROUPS_PER_FRAME - 1);

    drain_state_t          state, state_nxt;
    logic [BUF_PTR_W-1:0]  prev_fb;
    logic [2:0]            pending, pending_nxt;
    logic [5:0]            beat;
    logic                  inflight, inflight_last;
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [1:0]            skid_last;
    logic                  skid_wr, skid_rd;
    logic [1:0]            skid_cnt;

    logic advance, legal_adv, inc, release_blk, pend_ovf, xfer, credit_ok;

    assign advance     = dcts_frontbuffer != prev_fb;
    assign legal_adv   = dcts_frontbuffer == prev_fb + 2'd1;
    assign inc         = advance && legal_adv;
    assign out_valid   = (skid_cnt != 2'd0) && (state != ERR);
    assign out_data    = skid_data[skid_rd];
    assign out_last    = out_valid && skid_last[skid_rd];
    assign xfer        = out_valid && out_ready;
    assign release_blk = (state == DRAIN) && xfer && out_last;

    // Words already held or on their way from the RAM must fit the two skid slots.
    assign credit_ok = ({1'b0, skid_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, xfer});

`ifdef ZIGZAG_ORDER_EN
    zigzag_lut u_zigzag_lut (
        .k      (beat),
        .offset (rd_addr)
    );
`else
    assign rd_addr = beat;
`endif

    always_comb begin
        pending_nxt = pending;
        pend_ovf    = 1'b0;
        if (inc && !release_blk) begin
            if (pending == 3'd3) begin
                pend_ovf = 1'b1;
            end else begin
                pending_nxt = pending + 3'd1;
            end
        end else if (!inc && release_blk) begin
            pending_nxt = pending - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 3'd0) state_nxt = READ;
            end
            READ: begin
                rd_en = credit_ok;
                if (credit_ok && beat == LAST_BEAT) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (release_blk) state_nxt = (pending_nxt != 3'd0) ? READ : IDLE;
            end
            default: state_nxt = ERR;
        endcase
        if (pend_ovf) state_nxt = ERR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            prev_fb       <= '0;
            pending       <= 3'd0;
            beat          <= 6'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_buffer     <= '0;
            blocks_read   <= 3'd0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            skid_last     <= 2'b00;
            skid_wr       <= 1'b0;
            skid_rd       <= 1'b0;
            skid_cnt      <= 2'd0;
            for (int i = 0; i < 2; i++) skid_data[i] <= '0;
        end else begin
            state         <= state_nxt;
            prev_fb       <= dcts_frontbuffer;
            pending       <= pending_nxt;
            inflight      <= rd_en;
            inflight_last <= rd_en && (beat == LAST_BEAT);
            if (pend_ovf || (advance && !legal_adv)) overflow <= 1'b1;
            if (rd_en) beat <= beat + 6'd1;
            if (release_blk) begin
                rd_buffer   <= rd_buffer + 2'd1;
                blocks_read <= (blocks_read == LAST_BLOCK) ? 3'd0 : blocks_read + 3'd1;
            end
            frame_done <= release_blk && (blocks_read == LAST_BLOCK);
            // RAM data lands one cycle after its strobe, tagged with the last-beat flag.
            if (inflight) begin
                skid_data[skid_wr] <= rd_data;
                skid_last[skid_wr] <= inflight_last;
                skid_wr            <= ~skid_wr;
            end
            if (xfer) skid_rd <= ~skid_rd;
            skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, xfer};
        end
    end

endmodule

// File: tb/tb_dct_buffer_drain_fsm.sv
// tb/tb_dct_buffer_drain_fsm.sv - randomized self-checking bench with a stream-level reference model
module tb_dct_buffer_drain_fsm;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    dcts_frontbuffer = 2'd0;
    logic          rd_en;
    logic [1:0]    rd_buffer;
    logic [5:0]    rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [2:0]    blocks_read;
    logic          frame_done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    dct_buffer_drain_fsm #(.DATA_WIDTH(DW), .GROUPS_PER_FRAME(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .dcts_frontbuffer (dcts_frontbuffer),
        .rd_en            (rd_en),
        .rd_buffer        (rd_buffer),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .blocks_read      (blocks_read),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] ram [256];
    always @(posedge clock) if (rd_en) rd_data <= ram[{rd_buffer, rd_addr}];

    // Model state: whole-stream counters rather than per-cycle machine state.
    int m_prev = 0, m_adv = 0, m_rel = 0, m_issued = 0, m_words = 0;
    int m_ovf = 0, m_err = 0, m_fd = 0, fd_count = 0;
    int first_addr [4];
    bit rand_ready = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int off_of(int k);
`ifdef ZIGZAG_ORDER_EN
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi, row;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int i = 0; i <= hi - lo; i++) begin
                row = (s % 2 == 0) ? hi - i : lo + i;
                if (n == k) return row * 8 + (s - row);
                n++;
            end
        end
        return -1;
`else
        return k;
`endif
    endfunction

    task automatic model_reset();
        m_prev = 0; m_adv = 0; m_rel = 0; m_issued = 0; m_words = 0;
        m_ovf = 0; m_err = 0; m_fd = 0;
    endtask

    always @(negedge clock) begin
        int k, blk, pend;
        logic x, rel;
        check("overflow", overflow, m_ovf);
        check("blocks_read", blocks_read, m_rel % 8);
        check("rd_buffer", rd_buffer, m_rel % 4);
        check("frame_done", frame_done, m_fd);
        if (frame_done) fd_count++;
        if (m_err != 0) begin
            check("err_out_valid", out_valid, 0);
            check("err_rd_en", rd_en, 0);
        end
        if (rd_en) begin
            check("rd_addr", rd_addr, off_of(m_issued % 64));
            check("rd_buffer_issue", rd_buffer, (m_issued / 64) % 4);
            check("issue_block_completed", (m_issued / 64) < m_adv, 1);
            if (m_issued < 4) first_addr[m_issued] = rd_addr;
        end
        x = out_valid && out_ready;
        check("outstanding_le_2", (m_issued - m_words + int'(rd_en) - int'(x)) <= 2, 1);
        if (out_valid) begin
            k   = m_words % 64;
            blk = m_words / 64;
            check("out_data", out_data, ram[(blk % 4) * 64 + off_of(k)]);
            check("out_last", out_last, k == 63);
        end else begin
            check("out_last_idle", out_last, 0);
        end
        if (reset) begin
            model_reset();
        end else begin
            pend = m_adv - m_rel;
            rel  = x && (m_words % 64 == 63);
            if (x) m_words++;
            if (rd_en) m_issued++;
            m_fd = 0;
            if (rel) begin
                m_rel++;
                if (m_rel % 8 == 0) m_fd = 1;
            end
            if (int'(dcts_frontbuffer) != m_prev) begin
                if (int'(dcts_frontbuffer) == (m_prev + 1) % 4) begin
                    if (pend == 3 && !rel) begin
                        m_ovf = 1;
                        m_err = 1;
                    end else begin
                        m_adv++;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            m_prev = int'(dcts_frontbuffer);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dcts_frontbuffer = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_blocks(int target, int budget, string name);
        int n;
        n = 0;
        while (blocks_read != 3'(target % 8) && n < budget) begin
            tick();
            n++;
        end
        check(name, blocks_read, target % 8);
    endtask

    task automatic advance_to(int fb, int gap);
        dcts_frontbuffer = 2'(fb);
        repeat (gap) tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_blocks_read", blocks_read, 0);

        // Single buffer at full rate
        out_ready = 1'b1;
        dcts_frontbuffer = 2'd1;
        wait_blocks(1, 72, "single_release_in_time");
        tick();
        tick();
        check("single_rd_buffer", rd_buffer, 1);
        check("single_idle_rd_en", rd_en, 0);
        check("single_idle_valid", out_valid, 0);
`ifdef ZIGZAG_ORDER_EN
        check("zz_addr0", first_addr[0], 0);
        check("zz_addr1", first_addr[1], 1);
        check("zz_addr2", first_addr[2], 8);
        check("zz_addr3", first_addr[3], 16);
`else
        check("raster_addr1", first_addr[1], 1);
        check("raster_addr3", first_addr[3], 3);
`endif

        // Random backpressure over three buffers
        rand_ready = 1'b1;
        advance_to(2, 3);
        advance_to(3, 3);
        advance_to(0, 1);
        wait_blocks(4, 3000, "backpressure_three_blocks");

        // Fill to pending 3, then advance in the same cycle as a release
        rand_ready = 1'b0;
        out_ready = 1'b0;
        advance_to(1, 3);
        advance_to(2, 3);
        advance_to(3, 3);
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_last) && n < 200) begin
            tick();
            n++;
        end
        check("simul_last_seen", out_valid && out_last, 1);
        dcts_frontbuffer = 2'd0;
        tick();
        check("simul_no_overflow", overflow, 0);
        check("simul_blocks_read", blocks_read, 5);
        wait_blocks(8, 1000, "frame_wrap_blocks");
        tick();
        check("frame_done_once", fd_count, 1);

        // Illegal jump
        do_reset();
        dcts_frontbuffer = 2'd2;
        tick();
        check("illegal_jump_overflow", overflow, 1);

        // Overrun with a stalled consumer
        do_reset();
        check("overrun_cleared", overflow, 0);
        advance_to(1, 3);
        advance_to(2, 3);
        advance_to(3, 3);
        check("overrun_pre_overflow", overflow, 0);
        advance_to(0, 1);
        check("overrun_overflow", overflow, 1);
        check("overrun_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (5) tick();
        check("overrun_sticky", overflow, 1);
        check("overrun_rd_en", rd_en, 0);

        // Reset in the middle of a block
        do_reset();
        out_ready = 1'b1;
        dcts_frontbuffer = 2'd1;
        n = 0;
        while (m_words < 30 && n < 100) begin
            tick();
            n++;
        end
        check("midblock_reached_beat30", m_words >= 30, 1);
        reset = 1'b1;
        dcts_frontbuffer = 2'd0;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_blocks_read", blocks_read, 0);
        repeat (3) tick();
        check("midrst_no_stale_word", out_valid, 0);
        dcts_frontbuffer = 2'd1;
        wait_blocks(1, 100, "after_reset_block");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
